// File: rtl/hazard_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encoding,
// the per-cycle decision, and the bundle of pipeline-register controls.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    localparam logic PC_SEL_INC = 1'b0;
    localparam logic PC_SEL_TGT = 1'b1;

    typedef enum logic [2:0] {
        DEC_MEMWAIT  = 3'd0,
        DEC_REDIRECT = 3'd1,
        DEC_HALT     = 3'd2,
        DEC_LOADUSE  = 3'd3,
        DEC_NORMAL   = 3'd4
    } dec_t;

    typedef struct packed {
        logic if_en;
        logic pc_sel;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic back_en;
    } ctrl_t;

    // First match wins: a stalled memory freezes everything, even a redirect.
    function automatic dec_t pick_decision(input logic memwait, input logic redirect,
                                           input logic halt, input logic loaduse);
        dec_t d;
        if (memwait)       d = DEC_MEMWAIT;
        else if (redirect) d = DEC_REDIRECT;
        else if (halt)     d = DEC_HALT;
        else if (loaduse)  d = DEC_LOADUSE;
        else               d = DEC_NORMAL;
        return d;
    endfunction

    function automatic ctrl_t dec_ctrl(input dec_t dec);
        ctrl_t c;
        c = '0;
        c.pc_sel = PC_SEL_INC;
        case (dec)
            DEC_MEMWAIT: begin
                c = '0;
            end
            DEC_REDIRECT: begin
                c.if_en      = 1'b1;
                c.pc_sel     = PC_SEL_TGT;
                c.ifid_en    = 1'b1;
                c.ifid_flush = 1'b1;
                c.idex_en    = 1'b1;
                c.idex_flush = 1'b1;
                c.back_en    = 1'b1;
            end
            DEC_HALT, DEC_LOADUSE: begin
                // Hold IF and ID, push a bubble into EX, let older work move on.
                c.idex_en    = 1'b1;
                c.idex_flush = 1'b1;
                c.back_en    = 1'b1;
            end
            default: begin
                c.if_en   = 1'b1;
                c.ifid_en = 1'b1;
                c.idex_en = 1'b1;
                c.back_en = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] LP_MAX = {WIDTH{1'b1}};

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != LP_MAX)) begin
            count <= count + LP_ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use stalls,
// EX redirects, data-memory wait with watchdog, halt, and perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WD_W        = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_redirect,
    input  logic             i_ex_halt,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_if_en,
    output logic             o_pc_sel,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_back_en,
    output logic             o_halted,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [WD_W-1:0] LP_WD_ONE  = WD_W'(1);
    localparam logic [WD_W-1:0] LP_TIMEOUT = WD_W'(MEM_TIMEOUT);

    state_t          r_state;
    logic [WD_W-1:0] r_wd;

    logic            w_memwait;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_loaduse;
    logic            w_active;
    dec_t            w_dec;
    ctrl_t           w_ctrl;
    logic [WD_W-1:0] w_wd_next;
    logic            w_stall_inc;
    logic            w_flush_inc;

    assign w_memwait = i_mem_req & ~i_mem_ready;
    assign w_rs1_hit = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit = i_id_rs2_used & (i_id_rs2 == i_ex_rd);
    assign w_loaduse = i_ex_mem_read & (i_ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

    // RUN and MEM_WAIT share the decision; in MEM_WAIT it still picks memwait until ready.
    assign w_active = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);
    assign w_dec    = pick_decision(w_memwait, i_ex_redirect, i_ex_halt, w_loaduse);

    always_comb begin
        w_ctrl = '0;
        if (i_rst) begin
            w_ctrl.ifid_flush = 1'b1;
            w_ctrl.idex_flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN, ST_MEM_WAIT: begin
                    w_ctrl = dec_ctrl(w_dec);
                end
                ST_HALT: begin
                    w_ctrl.idex_flush = 1'b1;
                    w_ctrl.back_en    = ~w_memwait;
                end
                default: begin
                    w_ctrl = '0;
                end
            endcase
        end
    end

    assign o_if_en      = w_ctrl.if_en;
    assign o_pc_sel     = w_ctrl.pc_sel;
    assign o_ifid_en    = w_ctrl.ifid_en;
    assign o_ifid_flush = w_ctrl.ifid_flush;
    assign o_idex_en    = w_ctrl.idex_en;
    assign o_idex_flush = w_ctrl.idex_flush;
    assign o_back_en    = w_ctrl.back_en;
    assign o_halted     = ~i_rst & (r_state == ST_HALT);
    assign o_fault      = ~i_rst & (r_state == ST_FAULT);

    // Watchdog counts wait cycles; the first one is seen while still in RUN.
    assign w_wd_next = (r_state == ST_RUN) ? LP_WD_ONE : (r_wd + LP_WD_ONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_wd    <= '0;
        end else begin
            case (r_state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (w_dec == DEC_MEMWAIT) begin
                        r_wd    <= w_wd_next;
                        r_state <= (w_wd_next >= LP_TIMEOUT) ? ST_FAULT : ST_MEM_WAIT;
                    end else begin
                        r_wd    <= '0;
                        r_state <= (w_dec == DEC_HALT) ? ST_HALT : ST_RUN;
                    end
                end
                default: begin
                    r_state <= r_state;
                    r_wd    <= r_wd;
                end
            endcase
        end
    end

    assign w_stall_inc = ~i_rst & w_active & ~w_ctrl.if_en;
    assign w_flush_inc = ~i_rst & w_active & (w_dec == DEC_REDIRECT);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (w_stall_inc),
        .count (o_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .inc   (w_flush_inc),
        .count (o_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with small counters and a short watchdog.
module tb_hazard_ctrl;

    localparam int CNT_W = 3;
    // Control vector {if_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, back_en}
    localparam logic [6:0] C_NORMAL = 7'b1010101;
    localparam logic [6:0] C_REDIR  = 7'b1111111;
    localparam logic [6:0] C_RESET  = 7'b0001010;
    localparam logic [6:0] C_FROZEN = 7'b0000000;
    localparam logic [6:0] C_BUBBLE = 7'b0000011;
    localparam logic [6:0] M_NOIDEX = 7'b1111011;

    logic clk = 1'b0;
    logic i_rst;
    logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd;
    logic i_id_rs1_used, i_id_rs2_used, i_ex_mem_read, i_ex_redirect, i_ex_halt;
    logic i_mem_req, i_mem_ready;
    logic o_if_en, o_pc_sel, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush, o_back_en;
    logic o_halted, o_fault;
    logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;
    logic [6:0] ctl;

    int n_cmp = 0;
    int n_fail = 0;

    assign ctl = {o_if_en, o_pc_sel, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush, o_back_en};

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .WD_W(8), .MEM_TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
        .i_ex_rd(i_ex_rd), .i_ex_mem_read(i_ex_mem_read),
        .i_ex_redirect(i_ex_redirect), .i_ex_halt(i_ex_halt),
        .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready),
        .o_if_en(o_if_en), .o_pc_sel(o_pc_sel),
        .o_ifid_en(o_ifid_en), .o_ifid_flush(o_ifid_flush),
        .o_idex_en(o_idex_en), .o_idex_flush(o_idex_flush),
        .o_back_en(o_back_en), .o_halted(o_halted), .o_fault(o_fault),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_ex_rd = 5'd0;
        i_id_rs1_used = 1'b0; i_id_rs2_used = 1'b0;
        i_ex_mem_read = 1'b0; i_ex_redirect = 1'b0; i_ex_halt = 1'b0;
        i_mem_req = 1'b0; i_mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        i_rst = 1'b1; i_mem_req = 1'b1; i_mem_ready = 1'b0; i_ex_halt = 1'b1; i_ex_redirect = 1'b1;
        #3;
        n_cmp++; if (ctl !== C_RESET) begin n_fail++; $display("FAIL rst_ctl: got %b want %b", ctl, C_RESET); end
        n_cmp++; if ({o_halted, o_fault} !== 2'b00) begin n_fail++; $display("FAIL rst_status: got %b want 00", {o_halted, o_fault}); end
        tick();
        i_rst = 1'b0; idle();
        #3;
        n_cmp++; if ({o_stall_cnt, o_flush_cnt} !== '0) begin n_fail++; $display("FAIL rst_cnts: got %0d/%0d want 0/0", o_stall_cnt, o_flush_cnt); end
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL rst_run: got %b want %b", ctl, C_NORMAL); end
        tick();
    endtask

    task automatic test_loaduse();
        do_reset();
        i_ex_mem_read = 1'b1; i_ex_rd = 5'd5;
        i_id_rs1 = 5'd5; i_id_rs1_used = 1'b1; i_id_rs2 = 5'd1; i_id_rs2_used = 1'b1;
        #3;
        n_cmp++; if ((ctl & M_NOIDEX) !== C_BUBBLE) begin n_fail++; $display("FAIL lu_bubble: got %b want %b", ctl & M_NOIDEX, C_BUBBLE); end
        tick();
        i_ex_mem_read = 1'b0;
        #3;
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL lu_resume: got %b want %b", ctl, C_NORMAL); end
        n_cmp++; if (o_stall_cnt !== 3'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", o_stall_cnt); end
        tick();
        i_ex_mem_read = 1'b1; i_ex_rd = 5'd0; i_id_rs1 = 5'd0;
        #3;
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL lu_x0: got %b want %b", ctl, C_NORMAL); end
        tick();
        i_ex_rd = 5'd7; i_id_rs1 = 5'd3; i_id_rs2 = 5'd7; i_id_rs2_used = 1'b0;
        #3;
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL lu_unused_src: got %b want %b", ctl, C_NORMAL); end
        i_id_rs2_used = 1'b1;
        #1;
        n_cmp++; if ((ctl & M_NOIDEX) !== C_BUBBLE) begin n_fail++; $display("FAIL lu_rs2: got %b want %b", ctl & M_NOIDEX, C_BUBBLE); end
        tick();
        idle();
        #3;
        n_cmp++; if (o_stall_cnt !== 3'd2) begin n_fail++; $display("FAIL lu_stall_cnt2: got %0d want 2", o_stall_cnt); end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        i_ex_redirect = 1'b1;
        #3;
        n_cmp++; if (ctl !== C_REDIR) begin n_fail++; $display("FAIL rd_ctl: got %b want %b", ctl, C_REDIR); end
        tick();
        i_ex_redirect = 1'b0;
        #3;
        n_cmp++; if (o_flush_cnt !== 3'd1) begin n_fail++; $display("FAIL rd_flush_cnt: got %0d want 1", o_flush_cnt); end
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL rd_after: got %b want %b", ctl, C_NORMAL); end
        tick();
        i_ex_redirect = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd = 5'd5; i_id_rs1 = 5'd5; i_id_rs1_used = 1'b1;
        #3;
        n_cmp++; if (ctl !== C_REDIR) begin n_fail++; $display("FAIL rd_over_lu: got %b want %b", ctl, C_REDIR); end
        tick();
        idle();
        #3;
        n_cmp++; if ({o_flush_cnt, o_stall_cnt} !== {3'd2, 3'd0}) begin n_fail++; $display("FAIL rd_cnts: got %0d/%0d want 2/0", o_flush_cnt, o_stall_cnt); end
        tick();
    endtask

    task automatic test_memwait();
        do_reset();
        i_mem_req = 1'b1; i_mem_ready = 1'b0; i_ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_cmp++; if (ctl !== C_FROZEN) begin n_fail++; $display("FAIL mw_freeze[%0d]: got %b want %b", i, ctl, C_FROZEN); end
            tick();
        end
        i_mem_ready = 1'b1;
        #3;
        n_cmp++; if (ctl !== C_REDIR) begin n_fail++; $display("FAIL mw_ready: got %b want %b", ctl, C_REDIR); end
        tick();
        idle();
        #3;
        n_cmp++; if (o_stall_cnt !== 3'd3) begin n_fail++; $display("FAIL mw_stall_cnt: got %0d want 3", o_stall_cnt); end
        n_cmp++; if (o_flush_cnt !== 3'd1) begin n_fail++; $display("FAIL mw_flush_cnt: got %0d want 1", o_flush_cnt); end
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL mw_run: got %b want %b", ctl, C_NORMAL); end
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        i_mem_req = 1'b1; i_mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3;
            n_cmp++; if ({o_fault, ctl} !== {1'b0, C_FROZEN}) begin n_fail++; $display("FAIL wd_wait[%0d]: got %b want %b", i, {o_fault, ctl}, {1'b0, C_FROZEN}); end
            tick();
        end
        #3;
        n_cmp++; if (o_fault !== 1'b1) begin n_fail++; $display("FAIL wd_fault: got %b want 1", o_fault); end
        tick();
        i_mem_ready = 1'b1; i_ex_redirect = 1'b1;
        tick();
        #3;
        n_cmp++; if ({o_fault, ctl} !== {1'b1, C_FROZEN}) begin n_fail++; $display("FAIL wd_sticky: got %b want %b", {o_fault, ctl}, {1'b1, C_FROZEN}); end
        n_cmp++; if ({o_stall_cnt, o_flush_cnt} !== {3'd4, 3'd0}) begin n_fail++; $display("FAIL wd_cnts: got %0d/%0d want 4/0", o_stall_cnt, o_flush_cnt); end
        i_rst = 1'b1;
        #1;
        n_cmp++; if ({o_fault, ctl} !== {1'b0, C_RESET}) begin n_fail++; $display("FAIL wd_rst: got %b want %b", {o_fault, ctl}, {1'b0, C_RESET}); end
        tick();
        i_rst = 1'b0; idle();
        #3;
        n_cmp++; if ({o_fault, ctl, o_stall_cnt} !== {1'b0, C_NORMAL, 3'd0}) begin n_fail++; $display("FAIL wd_recover: got %b want %b", {o_fault, ctl, o_stall_cnt}, {1'b0, C_NORMAL, 3'd0}); end
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        i_ex_halt = 1'b1;
        #3;
        n_cmp++; if ({o_halted, ctl & M_NOIDEX} !== {1'b0, C_BUBBLE}) begin n_fail++; $display("FAIL ht_decide: got %b want %b", {o_halted, ctl & M_NOIDEX}, {1'b0, C_BUBBLE}); end
        tick();
        i_ex_halt = 1'b0;
        #3;
        n_cmp++; if ({o_halted, ctl & M_NOIDEX} !== {1'b1, C_BUBBLE}) begin n_fail++; $display("FAIL ht_state: got %b want %b", {o_halted, ctl & M_NOIDEX}, {1'b1, C_BUBBLE}); end
        tick();
        i_ex_redirect = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd = 5'd5; i_id_rs1 = 5'd5; i_id_rs1_used = 1'b1;
        #3;
        n_cmp++; if ({o_halted, ctl & M_NOIDEX} !== {1'b1, C_BUBBLE}) begin n_fail++; $display("FAIL ht_ignore_rd: got %b want %b", {o_halted, ctl & M_NOIDEX}, {1'b1, C_BUBBLE}); end
        tick();
        i_ex_redirect = 1'b0; i_mem_req = 1'b1; i_mem_ready = 1'b0;
        #3;
        n_cmp++; if (o_back_en !== 1'b0) begin n_fail++; $display("FAIL ht_drain_wait: got %b want 0", o_back_en); end
        n_cmp++; if (o_flush_cnt !== 3'd0) begin n_fail++; $display("FAIL ht_flush_cnt: got %0d want 0", o_flush_cnt); end
        tick();
        i_rst = 1'b1;
        #3;
        n_cmp++; if (o_halted !== 1'b0) begin n_fail++; $display("FAIL ht_rst: got %b want 0", o_halted); end
        tick();
        i_rst = 1'b0; idle();
        #3;
        n_cmp++; if ({o_halted, ctl} !== {1'b0, C_NORMAL}) begin n_fail++; $display("FAIL ht_recover: got %b want %b", {o_halted, ctl}, {1'b0, C_NORMAL}); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        i_ex_mem_read = 1'b1; i_ex_rd = 5'd9; i_id_rs2 = 5'd9; i_id_rs2_used = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        #3;
        n_cmp++; if (o_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_reach: got %0d want 7", o_stall_cnt); end
        for (int i = 0; i < 3; i++) tick();
        #3;
        n_cmp++; if (o_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_hold: got %0d want 7", o_stall_cnt); end
        n_cmp++; if ((ctl & M_NOIDEX) !== C_BUBBLE) begin n_fail++; $display("FAIL sat_ctl: got %b want %b", ctl & M_NOIDEX, C_BUBBLE); end
        tick();
        idle();
    endtask

    initial begin
        idle();
        i_rst = 1'b1;
        tick();
        test_reset();
        test_loaduse();
        test_redirect();
        test_memwait();
        test_watchdog();
        test_halt();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. Generates the `IF_EN` enable for the fetch PC register, the next-PC select, and the enable/flush controls for every pipeline register. It resolves load-use stalls, EX-stage redirects, data-memory wait states with a watchdog, and halt. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `CNT_W`, 16: width of the performance counters.
- `WD_W`, 8: width of the memory-wait watchdog.
- `MEM_TIMEOUT`, 200: number of consecutive wait cycles that triggers FAULT; must be < 2^WD_W.

- `i_clk` in 1: single clock; all state updates on the rising edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_id_rs1`, `i_id_rs2` in 5 each: source registers of the instruction in ID.
- `i_id_rs1_used`, `i_id_rs2_used` in 1 each: ID instruction actually reads that source.
- `i_ex_rd` in 5: destination register of the instruction in EX.
- `i_ex_mem_read` in 1: EX instruction is a load.
- `i_ex_redirect` in 1: taken branch or jump resolved in EX.
- `i_ex_halt` in 1: EX instruction is ebreak/halt.
- `i_mem_req`, `i_mem_ready` in 1 each: data-memory request/ready handshake for the MEM stage.
- `o_if_en` out 1: drives the fetch PC register enable.
- `o_pc_sel` out 1: 0 selects PC+4, 1 selects the EX target.
- `o_ifid_en`, `o_ifid_flush` out 1 each: IF/ID register enable and flush.
- `o_idex_en`, `o_idex_flush` out 1 each: ID/EX register enable and bubble insert.
- `o_back_en` out 1: enable for EX/MEM and MEM/WB.
- `o_halted`, `o_fault` out 1 each: status flags.
- `o_stall_cnt`, `o_flush_cnt` out CNT_W each: saturating performance counters.

## Operation
- States: RUN, MEM_WAIT, HALT, FAULT. Reset puts the FSM in RUN.
- Reset-cycle outputs:
  - enables = 0; `o_ifid_flush` = `o_idex_flush` = 1.
  - `o_pc_sel` = 0; counters = 0; watchdog = 0; `o_halted` = `o_fault` = 0.
- **memwait** = `i_mem_req & ~i_mem_ready`.
- **loaduse** = `i_ex_mem_read & (i_ex_rd != 0) & ((i_id_rs1_used & rs1 == rd) | (i_id_rs2_used & rs2 == rd))`. Register x0 never hazards.
- Decision priority in RUN, and in MEM_WAIT on the ready cycle (first match wins):
  1. **memwait**: all enables 0, no flush. State goes to MEM_WAIT and the watchdog is set to 1.
  2. **redirect**: `o_pc_sel` = 1, `o_if_en` = 1, `o_ifid_flush` = 1, `o_idex_flush` = 1, other enables 1. `o_flush_cnt` += 1.
  3. **halt**: `o_if_en` = 0, `o_ifid_en` = 0, `o_idex_flush` = 1, `o_back_en` = 1. State goes to HALT.
  4. **loaduse**: `o_if_en` = 0, `o_ifid_en` = 0, `o_idex_flush` = 1 (bubble), `o_back_en` = 1.
  5. **normal**: all enables 1, no flush, `o_pc_sel` = 0.
- MEM_WAIT:
  - While **memwait** holds: all enables 0, watchdog += 1. When the watchdog reaches MEM_TIMEOUT, state goes to FAULT.
  - On `i_mem_ready`: apply the RUN decision in the same cycle, go to RUN, clear the watchdog.
- HALT:
  - `o_halted` = 1; `o_if_en` = `o_ifid_en` = 0; `o_idex_flush` = 1.
  - `o_back_en` = ~**memwait**, so older instructions drain.
  - Exit only by reset. Redirect and loaduse inputs are ignored.
- FAULT: `o_fault` = 1, all enables 0, no flush. Exit only by reset.
- `o_stall_cnt` += 1 every cycle `o_if_en` = 0 while in RUN or MEM_WAIT.
- Both counters saturate at all-ones and never wrap.
- If a flush and an enable apply to the same register, the flush wins.

## Timing
- All control outputs are combinational from the registered state and the current inputs. There is zero-cycle latency from hazard to control.
- Redirect asserted at cycle N: PC = target at N+1. The two wrong-path instructions (IF/ID, ID/EX) are squashed at the N edge.
- Loaduse at N: one bubble. At N+1 the load is in MEM, the hazard clears, and ID proceeds.
- Memwait first seen at N: freeze from N, state MEM_WAIT at N+1. The ready cycle advances the pipeline.
- FAULT is entered on the edge where the watchdog equals MEM_TIMEOUT.
- Reset mid-MEM_WAIT, HALT or FAULT returns to RUN next cycle, with counters and watchdog cleared.

## Structure
- Shared package/header `hazard_pkg`: state encodings (RUN=0, MEM_WAIT=1, HALT=2, FAULT=3) and the `PC_SEL_INC`/`PC_SEL_TGT` constants.
- One sub-module, `sat_counter` (parameter width, ports clk, rst, inc, count), instantiated twice for the performance counters.

## Test plan
- **Load-use:** `lw x5` in EX, ID `add x6,x5,x1`. Expect one cycle with `o_if_en` = 0, `o_idex_flush` = 1, `o_stall_cnt` = 1; then normal. Same case with rd = x0 must produce no stall.
- **Redirect:** redirect at cycle 10. Expect `o_pc_sel` = 1 and both flushes at cycle 10, `o_flush_cnt` = 1, normal at 11. Redirect together with loaduse yields only the redirect.
- **Memory wait:** `i_mem_ready` low for 3 cycles. Expect 3 frozen cycles with no flush, then RUN; `o_stall_cnt` = 3.
- **Watchdog:** `i_mem_ready` held low with MEM_TIMEOUT = 4. Expect `o_fault` = 1 after the 4th wait cycle, sticky until `i_rst`.
- **Halt:** `i_ex_halt` pulse. Expect `o_halted` = 1 next cycle, `o_if_en` = 0, `o_back_en` = 1; later redirects ignored; reset clears the state.
- **Saturation:** with CNT_W = 3, force 10 stalls. Expect `o_stall_cnt` to hold at 7.
